// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO controller. It owns the read/write pointers, an occupancy
// counter, the full/empty and almost-full/almost-empty flags, a synchronous
// flush and optional sticky overflow/underflow flags. The storage array is
// external and is driven through wr_en/wraddr and rd_en/rdaddr.
//
// Optional feature macro: SYNC_FIFO_ERRFLAG_EN
//   defined     -> overflow/underflow are sticky error flags
//   not defined -> overflow/underflow are tied to 0 (ports still present)
//
// Parameters:
//   PTRWIDTH  address width, depth = 2**PTRWIDTH
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//
// Ports:
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous active-high reset (priority over flush)
//   push, pop     in   write / read requests
//   flush         in   synchronous clear (priority over push/pop)
//   wr_en, rd_en  out  combinational accept strobes
//   wraddr        out  write address (low bits of write pointer)
//   rdaddr        out  read address  (low bits of read pointer)
//   count         out  registered occupancy 0..2**PTRWIDTH
//   full, empty, almost_full, almost_empty  out  registered status flags
//   overflow, underflow                     out  sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int PTRWIDTH = 4,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  output logic                wr_en,
  output logic                rd_en,
  output logic [PTRWIDTH-1:0] wraddr,
  output logic [PTRWIDTH-1:0] rdaddr,
  output logic [PTRWIDTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int CW = PTRWIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** PTRWIDTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  // Reject illegal threshold settings at elaboration time.
  generate
    if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > (2 ** PTRWIDTH))) begin : g_bad_levels
      $error("sync_fifo_ctrl: need 0 <= AE_LEVEL < AF_LEVEL <= 2**PTRWIDTH");
    end
  endgenerate

  logic [CW-1:0] wrptr_q, wrptr_d;
  logic [CW-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;

  // Accept decisions use only registered flags, so push and pop are judged
  // independently: a simultaneous pop never frees room for a push on a full
  // FIFO, and a simultaneous push never feeds a pop on an empty one.
  // Nothing is accepted in a reset or flush cycle.
  always_comb begin
    wr_en = push & ~full_q  & ~flush & ~reset;
    rd_en = pop  & ~empty_q & ~flush & ~reset;
  end

  always_comb begin
    wrptr_d = wrptr_q + {{PTRWIDTH{1'b0}}, wr_en};
    rdptr_d = rdptr_q + {{PTRWIDTH{1'b0}}, rd_en};
    // Both accepted -> the +1 and -1 cancel and count holds.
    count_d = count_q + {{PTRWIDTH{1'b0}}, wr_en} - {{PTRWIDTH{1'b0}}, rd_en};
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
    end
    // Flags are derived from the next count so they line up with it.
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign wraddr       = wrptr_q[PTRWIDTH-1:0];
  assign rdaddr       = rdptr_q[PTRWIDTH-1:0];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

`ifdef SYNC_FIFO_ERRFLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset or flush; a request in a flush cycle is not an error.
  always_comb begin
    overflow_d  = overflow_q  | (push & full_q  & ~flush);
    underflow_d = underflow_q | (pop  & empty_q & ~flush);
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO controller: the synchronous-domain sibling and successor of our async FIFO pointer controllers. It owns both read and write pointers, an occupancy counter, full/empty and programmable almost-full/almost-empty flags, a synchronous flush, and optional sticky overflow/underflow error flags. The storage array sits outside this block and is driven by `wr_en`/`wraddr` and `rd_en`/`rdaddr`.

## Interface
- `PTRWIDTH`, 4, address width; depth = 2^PTRWIDTH (16).
- `AE_LEVEL`, 2, `almost_empty` asserted when count <= AE_LEVEL.
- `AF_LEVEL`, 14, `almost_full` asserted when count >= AF_LEVEL.

Ports:
- `clk`  in  1  single clock; all logic is on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `flush`  in  1  synchronous clear of contents.
- `wr_en`  out  1  combinational, push accepted this cycle.
- `rd_en`  out  1  combinational, pop accepted this cycle.
- `wraddr`  out  PTRWIDTH  write address, = wrptr_bin[PTRWIDTH-1:0].
- `rdaddr`  out  PTRWIDTH  read address, = rdptr_bin[PTRWIDTH-1:0].
- `count`  out  PTRWIDTH+1  registered occupancy, 0..2^PTRWIDTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  registered status flags.
- `overflow`, `underflow`  out  1 each  sticky error flags (see Configuration).

## Operation
- Internal `wrptr_bin`, `rdptr_bin`: PTRWIDTH+1 bits, binary, +1 on accept, wrap modulo 2^(PTRWIDTH+1) with the carry ignored.
- `wr_en = push & !full & !flush`; `rd_en = pop & !empty & !flush`.
- Push and pop are judged independently against the registered flags:
  - Push on a full FIFO is rejected, even when a pop is accepted in the same cycle.
  - Pop on an empty FIFO is rejected, even when a push is accepted in the same cycle.
- Count update: +1 for push only, -1 for pop only, unchanged when both are accepted.
- `full` = (count_next == 2^PTRWIDTH); `empty` = (count_next == 0). `full` must also equal the condition where the pointers are equal except in the MSB. Verification asserts this invariant.
- `almost_full`/`almost_empty` are computed from count_next against AF_LEVEL/AE_LEVEL and registered.
- `flush` has priority over push and pop. Next cycle: pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, and sticky errors are cleared.
- `reset` has priority over `flush` and gives the same end state.
- Reset values: count 0, wraddr 0, rdaddr 0, full 0, almost_full 0, empty 1, almost_empty 1, overflow 0, underflow 0.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= 2^PTRWIDTH. Check this at elaboration and `$error` if it is violated.

## Timing
- Accept decision is combinational in the request cycle. Pointer, count and flag updates are visible on the next posedge (1-cycle latency).
- The read address is valid in the cycle `rd_en` is high. Data timing is owned by the external RAM.
- A push into an empty FIFO deasserts `empty` one cycle later. The earliest accepted pop is 1 cycle after the accepted push.
- No combinational path from `push`/`pop` to any status flag; `wr_en`/`rd_en` are the only combinational outputs.
- Mid-operation reset or flush discards all contents within one cycle. No request in that cycle is accepted.

## Configuration
- `SYNC_FIFO_ERRFLAG_EN` defined:
  - `overflow` sets on push & full & !flush, and `underflow` sets on pop & empty & !flush.
  - Both flags are sticky until reset or flush.
  - Each flag rises 1 cycle after the offending request.
- `SYNC_FIFO_ERRFLAG_EN` not defined: `overflow` and `underflow` are tied to 0. The ports remain, so the interface is identical.

## Test plan
- Reset, then 16 pushes with no pops. Required:
  - count 0->16.
  - almost_full rises the cycle after the 14th push.
  - full rises the cycle after the 16th push.
  - wraddr returns to 0.
- While full, assert push+pop together. Required:
  - rd_en=1, wr_en=0, count 16->15, full drops.
  - With the macro defined, overflow=1 the next cycle.
- While empty, assert push+pop together. Required:
  - wr_en=1, rd_en=0, count 0->1.
  - With the macro defined, underflow=1.
  - Without the macro, underflow stays 0.
- Wrap-around: 40 cycles of alternating bursts of 10 pushes and 10 pops. Required:
  - Pointer MSB toggles, empty/full never both 1.
  - The full invariant against the pointers holds every cycle.
- At count=9, assert flush together with push+pop. Required:
  - wr_en=rd_en=0.
  - Next cycle count=0, empty=1, almost_empty=1, and sticky errors cleared.
- Assert reset mid-burst at count=7 with push held high. Required:
  - Next cycle all outputs are at their reset values.
  - The first push after reset is accepted at wraddr 0.
